// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: serial data, control and match-status bundle for seq_detect_param
interface seq_detect_param_if #(parameter int CNT_W = 8);
    logic             x_i;
    logic             in_en_i;
    logic             overlap_i;
    logic             clr_i;
    logic             y_o;
    logic             y_q_o;
    logic [CNT_W-1:0] match_cnt_o;
    logic             cnt_sat_o;
    modport slave  (input x_i, in_en_i, overlap_i, clr_i, output y_o, y_q_o, match_cnt_o, cnt_sat_o);
    modport master (output x_i, in_en_i, overlap_i, clr_i, input y_o, y_q_o, match_cnt_o, cnt_sat_o);
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: shift-window serial pattern detector with overlap select and saturating match counter
module seq_detect_param #(
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1010,
    parameter int                CNT_W   = 8
) (
    input logic                clk,
    input logic                rst_n,
    seq_detect_param_if.slave  bus
);
    localparam int FW = $clog2(PAT_W) + 1;
    logic [PAT_W-2:0] hist_q;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q;
    logic             y_q;
    logic [PAT_W-1:0] win;
    logic             full, y;
    assign win  = {hist_q, bus.x_i};
    assign full = fill_q == FW'(PAT_W - 1);
    assign y    = rst_n & bus.in_en_i & ~bus.clr_i & full & (win == PATTERN);
    // overlap keeps the window full so trailing bits can start the next match
    assign fill_d = y ? (bus.overlap_i ? fill_q : '0) : (full ? fill_q : fill_q + FW'(1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            y_q    <= 1'b0;
        end else if (bus.clr_i) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            y_q    <= 1'b0;
        end else begin
            y_q <= y;
            if (bus.in_en_i) begin
                hist_q <= win[PAT_W-2:0];
                fill_q <= fill_d;
            end
            if (y && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end
    assign bus.y_o         = y;
    assign bus.y_q_o       = y_q;
    assign bus.match_cnt_o = cnt_q;
    assign bus.cnt_sat_o   = &cnt_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: vector-table and directed checks of seq_detect_param with 8-bit and 3-bit counters
module tb_seq_detect_param;
    typedef struct {
        logic x, en, ov, clr, y, yq;
        int   cnt;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic x = 1'b0, en = 1'b0, ov = 1'b0, clr = 1'b0;
    int   total = 0, bad = 0;
    vec_t v[$];
    seq_detect_param_if #(.CNT_W(8)) b8();
    seq_detect_param_if #(.CNT_W(3)) b3();
    assign b8.x_i = x;  assign b8.in_en_i = en;  assign b8.overlap_i = ov;  assign b8.clr_i = clr;
    assign b3.x_i = x;  assign b3.in_en_i = en;  assign b3.overlap_i = ov;  assign b3.clr_i = clr;
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic check_all(input string tag, input logic ey, input logic eyq, input int ecnt);
        int c3 = ecnt > 7 ? 7 : ecnt;
        chk({tag, " y8"}, int'(b8.y_o), int'(ey));
        chk({tag, " yq8"}, int'(b8.y_q_o), int'(eyq));
        chk({tag, " cnt8"}, int'(b8.match_cnt_o), ecnt);
        chk({tag, " y3"}, int'(b3.y_o), int'(ey));
        chk({tag, " cnt3"}, int'(b3.match_cnt_o), c3);
        chk({tag, " sat3"}, int'(b3.cnt_sat_o), int'(c3 == 7));
        chk({tag, " sat8"}, int'(b8.cnt_sat_o), int'(ecnt == 255));
    endtask
    task automatic drive(input logic xi, input logic ei, input logic oi, input logic ci);
        @(negedge clk);
        x = xi; en = ei; ov = oi; clr = ci;
        #1;
    endtask
    initial begin
        int k;
        // overlapping stream 1010101, then idle with x=0 that would otherwise match
        v.push_back('{1,1,1,0,0,0,0}); v.push_back('{0,1,1,0,0,0,0});
        v.push_back('{1,1,1,0,0,0,0}); v.push_back('{0,1,1,0,1,0,0});
        v.push_back('{1,1,1,0,0,1,1}); v.push_back('{0,1,1,0,1,0,1});
        v.push_back('{1,1,1,0,0,1,2}); v.push_back('{0,0,1,0,0,0,2});
        v.push_back('{0,1,1,1,0,0,2});
        // same stream, non-overlapping
        v.push_back('{1,1,0,0,0,0,0}); v.push_back('{0,1,0,0,0,0,0});
        v.push_back('{1,1,0,0,0,0,0}); v.push_back('{0,1,0,0,1,0,0});
        v.push_back('{1,1,0,0,0,1,1}); v.push_back('{0,1,0,0,0,0,1});
        v.push_back('{1,1,0,0,0,0,1}); v.push_back('{0,1,1,1,0,0,1});
        // idle gap mid-pattern
        v.push_back('{1,1,1,0,0,0,0}); v.push_back('{0,1,1,0,0,0,0});
        v.push_back('{1,1,1,0,0,0,0}); v.push_back('{0,0,1,0,0,0,0});
        v.push_back('{0,0,1,0,0,0,0}); v.push_back('{0,0,1,0,0,0,0});
        v.push_back('{0,1,1,0,1,0,0}); v.push_back('{1,1,1,0,0,1,1});
        // clr beats a would-be match; then fresh 1010 needed
        v.push_back('{0,1,1,1,0,0,1}); v.push_back('{0,1,1,0,0,0,0});
        v.push_back('{1,1,1,0,0,0,0}); v.push_back('{0,1,1,0,0,0,0});
        v.push_back('{1,1,1,0,0,0,0}); v.push_back('{0,1,1,0,1,0,0});
        #1;
        check_all("reset", 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < v.size(); i++) begin
            drive(v[i].x, v[i].en, v[i].ov, v[i].clr);
            check_all($sformatf("vec%0d", i), v[i].y, v[i].yq, v[i].cnt);
        end
        // asynchronous reset while a match is pending
        drive(1, 1, 1, 0);
        check_all("pre_rst1", 1'b0, 1'b1, 1);
        drive(0, 1, 1, 0);
        check_all("pre_rst2", 1'b1, 1'b0, 1);
        rst_n = 1'b0;
        #1;
        check_all("in_rst", 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        #1;
        check_all("post_rst", 1'b0, 1'b0, 0);
        // saturation: 10 overlapping matches
        drive(0, 1, 1, 1);
        check_all("sat_clr", 1'b0, 1'b0, 0);
        k = 0;
        for (int p = 0; p < 11; p++) begin
            drive(1, 1, 1, 0);
            check_all($sformatf("sat%0d_1", p), 1'b0, p > 1, k);
            drive(0, 1, 1, 0);
            check_all($sformatf("sat%0d_0", p), p > 0, 1'b0, k);
            if (p > 0) k++;
        end
        drive(0, 0, 1, 0);
        check_all("sat_end", 1'b0, 1'b1, 10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
